freq_meter_ctrl: RTL and testbench
==================================

# freq_meter_ctrl

Measurement sequencer for the 5-digit BCD event counter: clears the counter, opens a count-enable gate for a fixed number of clock cycles, and latches the final digits into a display register. It also flags when the count passes 99999 during a window. It sits between the start/stop front-panel inputs and the counter/display path, in single-shot or continuous mode.

## Interface
- GATE_CYCLES, 50_000_000, gate window length in clk cycles (≥2); 1 s at 50 MHz
- HOLD_CYCLES, 25_000_000, display hold time after each latch (≥1)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  level; begins a measurement when sampled high in IDLE
- stop  in  1  level; aborts from any state
- cont  in  1  continuous mode; sampled at end of HOLD
- cnt_num1..cnt_num5  in  4 each  live counter digits, num1 = least significant
- cnt_clr  out  1  drives counter reset
- cnt_en  out  1  drives counter control (count enable)
- res_num1..res_num5  out  4 each  latched result digits
- ovf  out  1  latched result exceeded 99999
- done  out  1  one-cycle pulse, result registers updated
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, CLR, GATE, LATCH, HOLD. All outputs are registered.
- IDLE: cnt_clr=0, cnt_en=0. Go to CLR when start=1 and stop=0.
- CLR: cnt_clr=1 for exactly 1 cycle. Clear ovf_pend. Load the timer with GATE_CYCLES-1. Go to GATE.
- GATE: cnt_en=1 for exactly GATE_CYCLES cycles. Decrement the timer each cycle. When the timer is 0, go to LATCH.
- Overflow: in any GATE cycle where all five cnt_num digits are 9, set ovf_pend. The counter wraps on that edge.
- LATCH: cnt_en=0, 1 cycle, so the counter output is stable. On exit:
  - res_num* <= cnt_num*
  - ovf <= ovf_pend
  - done <= 1
  - load the timer with HOLD_CYCLES-1
- HOLD: count down HOLD_CYCLES cycles. Then go to CLR if cont=1, otherwise to IDLE.
- stop=1 in any non-IDLE state: next state IDLE, with cnt_en=0 and cnt_clr=0 in the following cycle. res_num*, ovf and done are unchanged and no done pulse is issued. An abort during LATCH's exit edge also suppresses the latch.
- start is ignored while busy. Simultaneous start and stop in IDLE: stop wins.
- reset (any state): state=IDLE, timer=0, ovf_pend=0. All outputs 0: cnt_clr, cnt_en, res_num1..5, ovf, done, busy.

## Timing
- Start sampled at edge T0 in IDLE:
  - CLR (cnt_clr=1, busy=1) during T0..T1
  - cnt_en=1 from T1 through T1+GATE_CYCLES
  - LATCH for 1 cycle
  - done=1 during the first HOLD cycle, i.e. GATE_CYCLES+2 cycles after the start edge
- Result equals the events counted over exactly GATE_CYCLES enabled edges, modulo 100000.
- Continuous period: 1 (CLR) + GATE_CYCLES + 1 (LATCH) + HOLD_CYCLES cycles.
- done is never high for two consecutive cycles.
- Timer width: clog2 of max(GATE_CYCLES, HOLD_CYCLES). The timer does not underflow; it is reloaded on every state entry that uses it.

## Structure
- Package freq_ctrl_pkg contains:
  - state enum (IDLE, CLR, GATE, LATCH, HOLD)
  - bcd_t (4-bit) typedef
  - NUM_DIGITS=5
  - BCD_MAX=9
- Sub-module gate_timer is a loadable down-counter:
  - inputs: load, load_val, dec
  - output: zero
  - parameter: WIDTH
  - it is instanced once and shared by GATE and HOLD.
- FSM, overflow detect and result registers live in freq_meter_ctrl.

## Test plan
Parameters for simulation: GATE_CYCLES=10, HOLD_CYCLES=4, with a behavioral counter model.
- Single shot: start pulse with cont=0 -> cnt_clr for 1 cycle, cnt_en for exactly 10 cycles, done at cycle 12, res=00010, ovf=0, then IDLE with busy=0 after 4 hold cycles.
- Continuous: cont=1, start once -> done pulses every 16 cycles. Drop cont -> the controller ends in IDLE after the current HOLD.
- Overflow: preload the counter model to 99995 instead of clearing -> res=00005, ovf=1. The next clean window gives ovf=0.
- Abort: stop at cycle 5 of GATE -> cnt_en low the following cycle, IDLE, no done pulse, prior res_num*/ovf held.
- Contention: start and stop high together in IDLE -> stays IDLE. start held high during GATE -> no restart or glitch.
- Reset mid-GATE: reset for 1 cycle -> all outputs 0 on the next cycle and state IDLE. A new start then gives the normal single-shot sequence.

Source files
------------

// File: rtl/freq_ctrl_pkg.sv
// Shared types and constants for the frequency-meter measurement sequencer.
package freq_ctrl_pkg;

  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned BCD_MAX    = 9;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [NUM_DIGITS-1:0] bcd_vec_t;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    GATE,
    LATCH,
    HOLD
  } state_t;

  // True when every digit shows the largest BCD value (count is 99999).
  function automatic logic all_max(input bcd_vec_t v);
    logic r;
    r = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (v[i] != bcd_t'(BCD_MAX)) r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_meter_ctrl_gate_timer.sv
// Loadable down-counter shared by the gate window and the display hold.
module gate_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/freq_meter_ctrl.sv
// Measurement sequencer: clear counter, open a fixed gate window, latch the
// BCD result with overflow flag, hold, then idle or repeat.
module freq_meter_ctrl
  import freq_ctrl_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned HOLD_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       cont,
  input  logic [3:0] cnt_num1,
  input  logic [3:0] cnt_num2,
  input  logic [3:0] cnt_num3,
  input  logic [3:0] cnt_num4,
  input  logic [3:0] cnt_num5,
  output logic       cnt_clr,
  output logic       cnt_en,
  output logic [3:0] res_num1,
  output logic [3:0] res_num2,
  output logic [3:0] res_num3,
  output logic [3:0] res_num4,
  output logic [3:0] res_num5,
  output logic       ovf,
  output logic       done,
  output logic       busy
);

  localparam int unsigned TMAX = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t          state_q, state_d;
  logic            t_load, t_dec, t_zero, latch;
  logic [TW-1:0]   t_val;
  logic            ovf_pend;
  bcd_vec_t        cnt_vec;

  assign cnt_vec = {cnt_num5, cnt_num4, cnt_num3, cnt_num2, cnt_num1};

  gate_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_comb begin
    state_d = state_q;
    t_load  = 1'b0;
    t_val   = '0;
    t_dec   = 1'b0;
    latch   = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = CLR;
      CLR: begin
        t_load  = 1'b1;
        t_val   = TW'(GATE_CYCLES - 32'd1);
        state_d = GATE;
      end
      GATE: begin
        if (t_zero) state_d = LATCH;
        else        t_dec   = 1'b1;
      end
      LATCH: begin
        t_load  = 1'b1;
        t_val   = TW'(HOLD_CYCLES - 32'd1);
        latch   = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (t_zero) state_d = cont ? CLR : IDLE;
        else        t_dec   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // stop overrides everything, including a pending latch and a start in IDLE
    if (stop) begin
      state_d = IDLE;
      t_load  = 1'b0;
      t_dec   = 1'b0;
      latch   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ovf_pend <= 1'b0;
      cnt_clr  <= 1'b0;
      cnt_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      res_num1 <= '0;
      res_num2 <= '0;
      res_num3 <= '0;
      res_num4 <= '0;
      res_num5 <= '0;
    end else begin
      state_q <= state_d;
      cnt_clr <= (state_d == CLR);
      cnt_en  <= (state_d == GATE);
      busy    <= (state_d != IDLE);
      done    <= latch;
      if (state_q == CLR) begin
        ovf_pend <= 1'b0;
      end else if ((state_q == GATE) && all_max(cnt_vec)) begin
        ovf_pend <= 1'b1;
      end
      if (latch) begin
        res_num1 <= cnt_num1;
        res_num2 <= cnt_num2;
        res_num3 <= cnt_num3;
        res_num4 <= cnt_num4;
        res_num5 <= cnt_num5;
        ovf      <= ovf_pend;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Scoreboard bench for freq_meter_ctrl with a behavioural BCD counter.
module tb_freq_meter_ctrl;

  localparam int G = 10;
  localparam int H = 4;
  localparam int P = G + H + 2;

  logic clk = 1'b0;
  logic reset, start, stop, cont;
  logic [3:0] cnt_num1, cnt_num2, cnt_num3, cnt_num4, cnt_num5;
  logic cnt_clr, cnt_en, ovf, done, busy;
  logic [3:0] res_num1, res_num2, res_num3, res_num4, res_num5;

  always #5 clk = ~clk;

  freq_meter_ctrl #(.GATE_CYCLES(G), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .cont(cont),
    .cnt_num1(cnt_num1), .cnt_num2(cnt_num2), .cnt_num3(cnt_num3),
    .cnt_num4(cnt_num4), .cnt_num5(cnt_num5),
    .cnt_clr(cnt_clr), .cnt_en(cnt_en),
    .res_num1(res_num1), .res_num2(res_num2), .res_num3(res_num3),
    .res_num4(res_num4), .res_num5(res_num5),
    .ovf(ovf), .done(done), .busy(busy)
  );

  // Event counter: one event per enabled edge; may be preloaded instead of cleared.
  int cnt_val = 0;
  bit preload_en = 0;
  int preload_val = 0;
  always @(posedge clk) begin
    if (cnt_clr)     cnt_val <= preload_en ? preload_val : 0;
    else if (cnt_en) cnt_val <= (cnt_val + 1) % 100000;
  end
  assign cnt_num1 = 4'(cnt_val % 10);
  assign cnt_num2 = 4'((cnt_val / 10) % 10);
  assign cnt_num3 = 4'((cnt_val / 100) % 10);
  assign cnt_num4 = 4'((cnt_val / 1000) % 10);
  assign cnt_num5 = 4'((cnt_val / 10000) % 10);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { int res; bit ovf; int t; } exp_t;
  exp_t sb[$];
  int last_res = 0;
  bit last_ovf = 0;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops an expectation for every done pulse.
  int en_run = 0;
  bit prev_done = 0;
  always @(negedge clk) begin
    if (reset) begin
      en_run = 0;
      prev_done = 0;
    end else begin
      if (cnt_clr) en_run = 0;
      if (cnt_en)  en_run++;
      if (done) begin : pop
        exp_t e;
        check("done_gap", 32'(prev_done), 0);
        check("gate_len", en_run, G);
        if (sb.size() == 0) begin
          check("spurious_done", 32'(done), 0);
        end else begin
          e = sb.pop_front();
          check("res", {res_num5, res_num4, res_num3, res_num2, res_num1}, to_bcd(e.res));
          check("ovf", 32'(ovf), 32'(e.ovf));
          check("done_time", cyc, e.t);
        end
      end
      prev_done = done;
    end
  end

  task automatic run_meas(input bit pre_en, input int pre_val, input int nwin,
                          input int stop_d, input bit hold_start);
    int t0, p, r;
    bit o;
    p = pre_en ? pre_val : 0;
    r = (p + G) % 100000;
    o = (p + G) >= 100000;
    preload_en = pre_en;
    preload_val = pre_val;
    start = 1;
    cont = (nwin > 1);
    t0 = cyc + 1;
    for (int k = 0; k < nwin; k++) begin
      if (stop_d < 0 || stop_d >= G + 2) begin
        sb.push_back('{res: r, ovf: o, t: t0 + k*P + G + 2});
        last_res = r;
        last_ovf = o;
      end
    end
    @(negedge clk);
    if (!hold_start) start = 0;
    for (int rel = 0; rel <= nwin*P; rel++) begin
      if (rel == nwin*P) begin
        check("idle_busy", 32'(busy), 0);
        check("idle_en", 32'(cnt_en), 0);
        break;
      end
      if (rel == 0)     check("clr_pulse", {cnt_clr, cnt_en, busy}, 3'b101);
      if (rel == 1)     check("gate_first", {cnt_clr, cnt_en}, 2'b01);
      if (rel == G)     check("gate_last", 32'(cnt_en), 1);
      if (rel == G + 1) check("latch_state", {cnt_clr, cnt_en, busy}, 3'b001);
      if (rel > 0 && rel % P == 0) check("cont_reclr", 32'(cnt_clr), 1);
      if (rel == (nwin-1)*P + G + 2) cont = 0;
      if (hold_start && rel == G + 2) start = 0;
      if (rel == stop_d) begin
        stop = 1;
        @(negedge clk);
        stop = 0;
        check("abort_out", {cnt_clr, cnt_en, busy}, 0);
        check("abort_res", {res_num5, res_num4, res_num3, res_num2, res_num1}, to_bcd(last_res));
        check("abort_ovf", 32'(ovf), 32'(last_ovf));
        @(negedge clk);
        check("abort_stay", 32'(busy), 0);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {cnt_clr, cnt_en, res_num5, res_num4, res_num3, res_num2, res_num1,
                 ovf, done, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int pv, nw, sd;
    bit pe;
    reset = 1; start = 0; stop = 0; cont = 0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    reset = 0;
    @(negedge clk);

    run_meas(0, 0, 1, -1, 0);           // single shot
    run_meas(0, 0, 3, -1, 0);           // continuous, three windows
    run_meas(1, 99995, 1, -1, 0);       // overflow
    run_meas(0, 0, 1, -1, 0);           // clean window clears ovf
    run_meas(1, 99990, 1, 5, 0);        // abort in GATE cycle 5

    start = 1; stop = 1;                // contention in IDLE
    @(negedge clk);
    check("contend", {busy, cnt_clr}, 0);
    start = 0; stop = 0;
    @(negedge clk);
    check("contend_idle", 32'(busy), 0);

    run_meas(0, 0, 1, -1, 1);           // start held through GATE

    preload_en = 0;                     // reset mid-GATE
    start = 1; cont = 0;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check_all_zero("reset_mid_gate");
    last_res = 0;
    last_ovf = 0;
    @(negedge clk);
    check("reset_idle", 32'(busy), 0);
    run_meas(0, 0, 1, -1, 0);

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pe = ($urandom_range(0, 2) == 0);
      pv = ($urandom_range(0, 1) == 0) ? int'($urandom_range(99985, 99999))
                                        : int'($urandom_range(0, 500));
      nw = $urandom_range(1, 3);
      sd = (nw == 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, P - 1)) : -1;
      run_meas(pe, pv, nw, sd, 0);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
